// File: rtl/event_pending_capture_pkg.sv
// Shared constants, FSM encoding and helpers for event_pending_capture.
// Source count, claim id width and the claim FSM state type.
package event_pending_capture_pkg;

  localparam int NR_SOURCES = 23;
  localparam int ID_W       = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic logic [NR_SOURCES-1:0] id_onehot(
    input logic [ID_W-1:0] id
  );
    logic [NR_SOURCES-1:0] v;
    v = '0;
    for (int i = 0; i < NR_SOURCES; i++) begin
      if (id == ID_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/event_pending_capture_encoder.sv
// Lowest-set-index encoder: 23-bit vector to 5-bit index.
// valid is high when any bit of vec is set.
module lowest_set_encoder_23
  import event_pending_capture_pkg::*;
(
  input  logic [NR_SOURCES-1:0] vec,
  output logic                  valid,
  output logic [ID_W-1:0]       index
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NR_SOURCES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        index = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/event_pending_capture.sv
// Event pending capture with single-claim offer/service handshake.
// Optional EVENT_PENDING_SYNC_EN adds a 2-flop input synchronizer.
module event_pending_capture
  import event_pending_capture_pkg::*;
#(
  parameter logic [NR_SOURCES-1:0] EdgeMask = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NR_SOURCES-1:0] Req_in,
  input  logic [NR_SOURCES-1:0] Enable_mask,
  output logic [NR_SOURCES-1:0] Pending,
  output logic                  Any_pending,
  output logic                  Claim_valid,
  output logic [ID_W-1:0]       Claim_id,
  input  logic                  Claim_ready,
  input  logic                  Complete,
  input  logic [ID_W-1:0]       Complete_id
);

  logic [NR_SOURCES-1:0] req_src;
  logic [NR_SOURCES-1:0] req_q;
  logic [NR_SOURCES-1:0] req_prev;
  logic [NR_SOURCES-1:0] edge_hit;
  logic [NR_SOURCES-1:0] raw_q;
  logic [NR_SOURCES-1:0] raw_d;
  logic [NR_SOURCES-1:0] clr;
  logic [NR_SOURCES-1:0] in_service;
  logic                  any_q;
  logic                  accept;
  logic                  enc_valid;
  logic [ID_W-1:0]       enc_idx;
  logic [ID_W-1:0]       claim_id_q;
  logic [ID_W-1:0]       claim_id_d;
  state_t                state_q;
  state_t                state_d;

`ifdef EVENT_PENDING_SYNC_EN
  logic [NR_SOURCES-1:0] sync_a;
  logic [NR_SOURCES-1:0] sync_b;

  // Two-flop synchronizer ahead of the input register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= Req_in;
      sync_b <= sync_a;
    end
  end

  assign req_src = sync_b;
`else
  assign req_src = Req_in;
`endif

  assign edge_hit   = req_q & ~req_prev;
  assign accept     = Claim_valid & Claim_ready;
  assign clr        = accept ? id_onehot(claim_id_q) : '0;
  assign in_service = (state_q == SERVICE) ? id_onehot(claim_id_q) : '0;

  // Edge bits latch until claimed (a new edge wins); level bits follow.
  always_comb begin
    raw_d = (EdgeMask & (edge_hit | (raw_q & ~clr)))
          | (~EdgeMask & req_q);
  end

  assign Pending     = raw_q & Enable_mask & ~in_service;
  assign Any_pending = any_q;
  assign Claim_valid = (state_q == OFFER);
  assign Claim_id    = claim_id_q;

  lowest_set_encoder_23 u_enc (
    .vec   (Pending),
    .valid (enc_valid),
    .index (enc_idx)
  );

  // Input, history, pending and FSM registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      req_q      <= '0;
      req_prev   <= '0;
      raw_q      <= '0;
      any_q      <= 1'b0;
      state_q    <= IDLE;
      claim_id_q <= '0;
    end else begin
      req_q      <= req_src;
      req_prev   <= req_q;
      raw_q      <= raw_d;
      any_q      <= |Pending;
      state_q    <= state_d;
      claim_id_q <= claim_id_d;
    end
  end

  // Claim FSM: pick lowest pending, offer it, hold until completed.
  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          claim_id_d = enc_idx;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (Claim_ready) state_d = SERVICE;
      end
      SERVICE: begin
        if (Complete && (Complete_id == claim_id_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_event_pending_capture.sv
// Scoreboard bench for event_pending_capture.
// Expected claim ids are queued by stimulus, checked at handshake.
module tb_event_pending_capture;
  import event_pending_capture_pkg::*;

  logic                  Clock;
  logic                  Reset;
  logic [NR_SOURCES-1:0] Req_in;
  logic [NR_SOURCES-1:0] Enable_mask;
  logic [NR_SOURCES-1:0] Pending;
  logic                  Any_pending;
  logic                  Claim_valid;
  logic [ID_W-1:0]       Claim_id;
  logic                  Claim_ready;
  logic                  Complete;
  logic [ID_W-1:0]       Complete_id;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  event_pending_capture #(
    .EdgeMask (23'h7FFFFE)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Req_in      (Req_in),
    .Enable_mask (Enable_mask),
    .Pending     (Pending),
    .Any_pending (Any_pending),
    .Claim_valid (Claim_valid),
    .Claim_id    (Claim_id),
    .Claim_ready (Claim_ready),
    .Complete    (Complete),
    .Complete_id (Complete_id)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted offer must match the next queued id.
  always @(negedge Clock) begin : mon
    int e;
    if (!Reset && Claim_valid && Claim_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL claim_unexpected: got id %0d required none",
                 Claim_id);
      end else begin
        e = exp_q.pop_front();
        check("claim_id", 32'(Claim_id), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!Claim_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!Claim_valid) begin
      errors++;
      $display("FAIL %s: Claim_valid 0 after %0d cycles required 1",
               name, n);
    end
  endtask

  task automatic accept();
    Claim_ready = 1'b1;
    step();
    Claim_ready = 1'b0;
  endtask

  task automatic complete(input logic [ID_W-1:0] id);
    Complete    = 1'b1;
    Complete_id = id;
    step();
    Complete    = 1'b0;
    Complete_id = '0;
  endtask

  task automatic pulse(input logic [NR_SOURCES-1:0] bits);
    Req_in = Req_in | bits;
    step();
    Req_in = Req_in & ~bits;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset       = 1'b1;
    Req_in      = 23'h000002;
    Enable_mask = '1;
    Claim_ready = 1'b0;
    Complete    = 1'b0;
    Complete_id = '0;

    // Reset state
    #2;
    check("rst_pending", 32'(Pending), 32'h0);
    check("rst_any", 32'(Any_pending), 32'h0);
    check("rst_valid", 32'(Claim_valid), 32'h0);
    check("rst_id", 32'(Claim_id), 32'h0);
    step_n(2);
    check("rst_pending_held", 32'(Pending), 32'h0);

    // Source 1 high across reset release counts as an edge
    #5;
    exp_q.push_back(1);
    Reset = 1'b0;
    wait_valid("start_edge");
    Req_in = '0;
    accept();
    check("start_srv_pending", 32'(Pending), 32'h0);
    complete(5'd1);
    check("start_done_valid", 32'(Claim_valid), 32'h0);
    check("start_done_pending", 32'(Pending), 32'h0);
    step_n(2);

    // Edge capture and claim on source 4
    exp_q.push_back(4);
    pulse(23'h000010);
    check("s1_pend_k", 32'(Pending), 32'h0);
    step();
    check("s1_pend_k1", 32'(Pending), 32'h10);
    check("s1_any_k1", 32'(Any_pending), 32'h0);
    check("s1_valid_k1", 32'(Claim_valid), 32'h0);
    step();
    check("s1_valid_k2", 32'(Claim_valid), 32'h1);
    check("s1_id_k2", 32'(Claim_id), 32'h4);
    check("s1_any_k2", 32'(Any_pending), 32'h1);
    accept();
    check("s1_srv_pending", 32'(Pending), 32'h0);
    complete(5'd4);
    check("s1_done_valid", 32'(Claim_valid), 32'h0);
    check("s1_done_any", 32'(Any_pending), 32'h0);
    step_n(2);

    // Priority 2 before 7; bad completes ignored
    exp_q.push_back(2);
    exp_q.push_back(7);
    pulse(23'h000084);
    wait_valid("s2_first");
    check("s2_first_id", 32'(Claim_id), 32'h2);
    accept();
    check("s2_other_pending", 32'(Pending), 32'h80);
    complete(5'd31);
    complete(5'd20);
    step();
    check("s2_bad_complete", 32'(Claim_valid), 32'h0);
    complete(5'd2);
    wait_valid("s2_second");
    accept();
    complete(5'd7);
    check("s2_done_pending", 32'(Pending), 32'h0);
    step_n(2);

    // Level source 0
    exp_q.push_back(0);
    exp_q.push_back(0);
    Req_in[0] = 1'b1;
    wait_valid("s3_first");
    accept();
    check("s3_in_service", 32'(Pending), 32'h0);
    step();
    check("s3_in_service2", 32'(Pending), 32'h0);
    complete(5'd0);
    check("s3_reassert", 32'(Pending), 32'h1);
    wait_valid("s3_second");
    Req_in[0] = 1'b0;
    accept();
    step();
    complete(5'd0);
    check("s3_done_pending", 32'(Pending), 32'h0);
    step();
    check("s3_done_valid", 32'(Claim_valid), 32'h0);
    step();

    // Set wins over clear on source 9
    exp_q.push_back(9);
    exp_q.push_back(9);
    pulse(23'h000200);
    wait_valid("s4_first");
    Req_in[9] = 1'b1;
    step();
    Claim_ready = 1'b1;
    Req_in[9]   = 1'b0;
    step();
    Claim_ready = 1'b0;
    check("s4_in_service", 32'(Pending), 32'h0);
    complete(5'd9);
    check("s4_set_wins", 32'(Pending), 32'h200);
    wait_valid("s4_second");
    accept();
    complete(5'd9);
    check("s4_done_pending", 32'(Pending), 32'h0);
    step_n(2);

    // Mask drop during offer of source 5
    exp_q.push_back(5);
    pulse(23'h000020);
    wait_valid("s5_offer");
    Enable_mask[5] = 1'b0;
    step_n(2);
    check("s5_hold_valid", 32'(Claim_valid), 32'h1);
    check("s5_hold_id", 32'(Claim_id), 32'h5);
    check("s5_masked", 32'(Pending), 32'h0);
    complete(5'd5);
    check("s5_complete_in_offer", 32'(Claim_valid), 32'h1);
    accept();
    Enable_mask = '1;
    complete(5'd5);
    check("s5_done_valid", 32'(Claim_valid), 32'h0);
    step_n(2);

    // Masked edge source still captures
    Enable_mask[6] = 1'b0;
    exp_q.push_back(6);
    pulse(23'h000040);
    step_n(3);
    check("s6_masked_pending", 32'(Pending), 32'h0);
    check("s6_masked_valid", 32'(Claim_valid), 32'h0);
    Enable_mask = '1;
    #1;
    check("s6_reenable", 32'(Pending), 32'h40);
    wait_valid("s6_offer");
    accept();
    complete(5'd6);
    step_n(2);

    // Asynchronous reset mid-service
    exp_q.push_back(3);
    pulse(23'h000008);
    wait_valid("s7_offer");
    accept();
    check("s7_any_before", 32'(Any_pending), 32'h1);
    check("s7_id_before", 32'(Claim_id), 32'h3);
    #2;
    Reset = 1'b1;
    #1;
    check("s7_rst_pending", 32'(Pending), 32'h0);
    check("s7_rst_any", 32'(Any_pending), 32'h0);
    check("s7_rst_valid", 32'(Claim_valid), 32'h0);
    check("s7_rst_id", 32'(Claim_id), 32'h0);
    #2;
    Reset = 1'b0;
    step();
    complete(5'd3);
    step_n(3);
    check("s7_after_valid", 32'(Claim_valid), 32'h0);
    check("s7_after_pending", 32'(Pending), 32'h0);
    check("s7_after_any", 32'(Any_pending), 32'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL claims_left: got %0d queued required 0",
               exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
